// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle instruction sequencer. It steps each instruction
//               through FETCH / DECODE / EXEC / MEM / WB / BRANCH and drives the
//               ALU, register-file, PC and memory-port controls for each state.
//               It includes a memory ready handshake, load/store sequencing and
//               a count of retired instructions.
// Ports       : clk, rst (sync, active-high)
//               op        - opcode from instruction register (valid in DECODE)
//               zero      - ALU zero flag, used in BRANCH
//               mem_ready - memory completes the current request
//               mem_req/mem_we, ir_load, pc_write/pc_src, alu_ctrl,
//               alu_src_imm, op_swap, reg_we, mem_to_reg - datapath controls
//               illegal   - unrecognised opcode indication
//               state_o   - current state, retired - completed instructions
// Options     : ILLEGAL_TRAP_EN - when this is defined, an unrecognised opcode
//               sets a sticky illegal flag and halts until reset. Otherwise
//               such an opcode runs as ALU op 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int OP_W        = 6,
  parameter int ALU_W       = 3,
  parameter int CNT_W       = 16,
  parameter int NUM_ALU_OPS = 6,
  parameter int OP_BEQ      = 10,
  parameter int OP_ADDI     = 11,
  parameter int OP_LW       = 12,
  parameter int OP_SW       = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_src,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             alu_src_imm,
  output logic             op_swap,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam logic [OP_W-1:0] c_num_alu = OP_W'(NUM_ALU_OPS);
  localparam logic [OP_W-1:0] c_beq     = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] c_addi    = OP_W'(OP_ADDI);
  localparam logic [OP_W-1:0] c_lw      = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] c_sw      = OP_W'(OP_SW);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_retired;

  function automatic logic is_alu(input logic [OP_W-1:0] o);
    return o < c_num_alu;
  endfunction

  function automatic logic is_known(input logic [OP_W-1:0] o);
    return is_alu(o) || (o == c_beq) || (o == c_addi) || (o == c_lw) || (o == c_sw);
  endfunction

  // DECODE must classify the live opcode because op_q only holds it from
  // the next cycle onward.
  logic w_dec_bad;
  assign w_dec_bad = (r_state == S_DECODE) && !is_known(op);

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_retired <= '0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op <= op;
          if (op == c_beq) begin
            r_state <= S_BRANCH;
          end else if (is_known(op)) begin
            r_state <= S_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
`else
            r_state   <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          if (r_op == c_lw || r_op == c_sw) r_state <= S_MEM;
          else                              r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (r_op == c_lw) begin
              r_state <= S_WB;
            end else begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 1'b1;
            end
          end
        end
        S_WB, S_BRANCH: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + 1'b1;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Moore control decode; FETCH handshake strobes follow mem_ready directly.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_ctrl    = '0;
    alu_src_imm = 1'b0;
    op_swap     = 1'b0;
    reg_we      = 1'b0;
    mem_to_reg  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_load  = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          // Unrecognised opcodes fall through here as ALU op 0.
          if (is_alu(r_op)) alu_ctrl = r_op[ALU_W-1:0];
          alu_src_imm = (r_op == c_addi) || (r_op == c_lw) || (r_op == c_sw);
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (r_op == c_sw);
        end
        S_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (r_op == c_lw);
        end
        S_BRANCH: begin
          alu_src_imm = 1'b1;
          op_swap     = 1'b1;
          pc_src      = 1'b1;
          pc_write    = zero;
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = !rst && (r_illegal || w_dec_bad);
`else
  assign illegal = !rst && w_dec_bad;
`endif

  assign state_o = rst ? 3'd0 : r_state;
  assign retired = rst ? '0 : r_retired;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder in the CPU datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH states and drives the ALU, register-file, PC and memory controls per state. It adds a memory ready handshake, load/store support and a retired-instruction counter. It sits between the instruction register (opcode source) and the datapath and memory port.

Parameters:
OP_W, 6, opcode width
ALU_W, 3, ALU control width
CNT_W, 16, retired-instruction counter width
NUM_ALU_OPS, 6, opcodes 0..NUM_ALU_OPS-1 are register-register ALU ops; alu_ctrl = op[ALU_W-1:0]
OP_BEQ, 10, branch-if-equal opcode
OP_ADDI, 11, add-immediate opcode
OP_LW, 12, load-word opcode
OP_SW, 13, store-word opcode

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
op  in  OP_W  opcode from instruction register; valid from DECODE onward
zero  in  1  ALU zero flag; sampled in BRANCH
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store qualifier, valid with mem_req
ir_load  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  0 = PC+1, 1 = branch target
alu_ctrl  out  ALU_W  ALU operation
alu_src_imm  out  1  ALU operand B = immediate
op_swap  out  1  swap ALU operands (branch compare)
reg_we  out  1  register-file write enable
mem_to_reg  out  1  writeback data from memory
illegal  out  1  unrecognised opcode seen
state_o  out  3  current state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 BRANCH=5 HALT=6
retired  out  CNT_W  completed-instruction count

Behaviour:
- rst high: state to FETCH, op_q, illegal and retired to 0; all outputs forced 0 while rst is high. First FETCH outputs appear in the cycle after rst falls.
- Outputs are Moore, decoded from state and latched op_q. Outputs not listed for a state are 0.
- FETCH: mem_req=1, mem_we=0. Wait while mem_ready=0. When mem_ready=1, assert ir_load=1 and pc_write=1 (pc_src=0) in the same cycle, then go to DECODE.
- DECODE: latch op into op_q, then dispatch:
  - ALU op, ADDI, LW or SW: go to EXEC.
  - BEQ: go to BRANCH.
  - Other opcode: see Optional Feature.
- EXEC:
  - ALU op: alu_ctrl=op_q[ALU_W-1:0]; next state WB.
  - ADDI: alu_ctrl=0, alu_src_imm=1; next state WB.
  - LW/SW: alu_ctrl=0, alu_src_imm=1 (address calculation); next state MEM.
- MEM: mem_req=1, mem_we=(op_q==OP_SW). Wait on mem_ready. On completion, LW goes to WB; SW goes to FETCH and counts as retired.
- WB: reg_we=1, mem_to_reg=(op_q==OP_LW). Retire the instruction, then go to FETCH.
- BRANCH: alu_ctrl=0, alu_src_imm=1, op_swap=1, pc_src=1, pc_write=zero. Retire, then go to FETCH.
- Latency with mem_ready tied high:
  - ALU op and ADDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
  - Each wait cycle on mem_ready adds one cycle.
- retired increments by 1 on the last cycle of each instruction and wraps modulo 2^CNT_W without a flag.
- mem_ready is ignored when mem_req=0.
- Reset mid-transaction: the request is abandoned, mem_req is 0 during reset, and the sequence restarts at FETCH with no retire.
- op changes after DECODE have no effect, because op_q is used.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE sets illegal=1 (sticky) and goes to HALT. HALT drives all controls 0, never retires, and holds until rst.
- Undefined: an unrecognised opcode is executed as ALU op 0 (EXEC, then WB with alu_ctrl=0, reg_we=1). illegal still pulses 1 for the DECODE cycle only.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1: outputs all 0 during reset; state_o=0, mem_req=1 in the first cycle after.
- op=3, mem_ready=1: state_o sequence 0,1,2,4; alu_ctrl=3 in EXEC; reg_we=1 for exactly 1 cycle; retired goes 0->1.
- op=12 (LW), mem_ready low for 2 cycles in MEM: MEM lasts 3 cycles with mem_req=1 and mem_we=0; WB has mem_to_reg=1; 7 cycles total.
- op=10 (BEQ) with zero=1, then again with zero=0: first gives pc_write=1 and pc_src=1 in BRANCH; second gives pc_write=0; each takes 3 cycles.
- op=13 (SW): mem_we=1 in MEM, reg_we never asserted; rst asserted mid-MEM drops mem_req and leaves retired unchanged.
- op=63: with ILLEGAL_TRAP_EN, state_o=6 and illegal=1 held for 10+ cycles with no retire; without it, WB occurs with alu_ctrl=0 and retired increments.
